csr_file: RTL and testbench
===========================

// Module: csr_file
// PURPOSE
//  Machine-mode CSR register file and trap sequencer, the responder for the exe stage's CSR requests.
//  - Read side: serves exe-stage CSR reads.
//  - Write side: commits CSR writes from the exe_mem stage.
//  - Traps: takes machine timer/external interrupts, ecall/ebreak and mret, and issues a one-cycle redirect to the fetch stage.
// PARAMETERS
//  MTVEC_RESET   32'h0000_0000  reset value of mtvec (base + mode)
//  HART_ID       32'd0          value returned by mhartid
//  MISA_VALUE    32'h4000_1100  RV32IM, read-only
// PORTS
//  clk_i            in   1   clock; all state updates on rising edge
//  rst_i            in   1   reset; synchronous, active-low
//  csr_raddr_i      in   12  CSR read address from exe
//  csr_rdata_o      out  32  read data (combinational)
//  csr_we_i         in   1   CSR write enable from exe_mem
//  csr_waddr_i      in   12  CSR write address
//  csr_wdata_i      in   32  CSR write data (already merged for RS/RC)
//  inst_valid_i     in   1   exe stage holds a real instruction (not bubble/stall)
//  inst_addr_i      in   32  PC of exe-stage instruction
//  ecall_i          in   1   exe instruction is ecall
//  ebreak_i         in   1   exe instruction is ebreak
//  mret_i           in   1   exe instruction is mret
//  timer_irq_i      in   1   level machine timer interrupt
//  ext_irq_i        in   1   level machine external interrupt
//  trap_jump_o      out  1   redirect + flush IF/ID/EXE this cycle
//  trap_addr_o      out  32  redirect target
// BEHAVIOUR
//  Reset (rst_i==0 at edge): mstatus.MIE=0, MPIE=0; mie=0; mepc=0; mcause=0; mscratch=0; mtvec=MTVEC_RESET; mcycle=0.
//    FSM goes to IDLE. trap_jump_o=0, trap_addr_o=0.
//  Map (unlisted addresses read 0; writes to them are ignored):
//    mstatus 0x300: MIE[3] and MPIE[7] writable; MPP[12:11] reads 2'b11.
//    misa 0x301: RO.
//    mie 0x304: bits 7 and 11 writable.
//    mtvec 0x305: bit1 reads 0.
//    mscratch 0x340.
//    mepc 0x341: [1:0] read 0.
//    mcause 0x342.
//    mip 0x344: RO; bit7=timer_irq_i, bit11=ext_irq_i.
//    mcycle 0xB00, mcycleh 0xB80.
//    mhartid 0xF14: RO.
//  Read: csr_rdata_o combinational. If csr_we_i && csr_waddr_i==csr_raddr_i, return the post-write legalised value (write-first bypass).
//  mcycle: 64-bit counter, +1 every cycle; wraps 2^64-1 -> 0.
//    A write to 0xB00/0xB80 loads that half that cycle; the other half holds, and there is no increment that cycle.
//  Trap acceptance (evaluated in IDLE, requires inst_valid_i); priority high to low:
//    1) ebreak: mcause=3.
//    2) ecall: mcause=11.
//    3) MEI: mie[11]&mip[11]&MIE; mcause=32'h8000_000B.
//    4) MTI: mie[7]&mip[7]&MIE; mcause=32'h8000_0007.
//    5) mret.
//  Trap at cycle N: at edge end of N, commit mepc<=inst_addr_i, mcause, MPIE<=MIE, MIE<=0; FSM IDLE->TRAP.
//  mret at cycle N: at edge end of N, MIE<=MPIE, MPIE<=1; FSM IDLE->RET.
//  TRAP state (cycle N+1): trap_jump_o=1.
//    trap_addr_o = {mtvec[31:2],2'b0}, or +4*cause[4:0] when mtvec[0]==1 and the cause is an interrupt.
//    Next state IDLE.
//  RET state (cycle N+1): trap_jump_o=1, trap_addr_o=mepc. Next state IDLE.
//  No acceptance in TRAP/RET (the flushed instruction is a bubble). Latency: exactly 1 cycle, acceptance -> redirect.
//  Same-cycle csr_we_i and trap/mret: trap/mret updates to mstatus/mepc/mcause win.
//    Writes to other CSRs still commit.
//  Interrupt lines are level-sensitive and not latched; deasserting before acceptance cancels the request.
//  Reset mid-TRAP/RET: redirect is dropped; outputs are 0 the next cycle.
// STRUCTURE
//  defines.v gains:
//    - CSR address constants (CSR_MSTATUS .. CSR_MHARTID)
//    - cause codes
//    - FSM state encodings (S_IDLE/S_TRAP/S_RET, 2 bits)
//    - CSR_ADDR_WIDTH = 12
//  One sub-module: csr_counter64 (64-bit counter with split lo/hi load).
//  Top: storage regs, write legalisation, read mux, priority logic, FSM.
// TESTING
//  1) Reset low 2 cycles -> read 0x305 = MTVEC_RESET, 0x300 = 32'h1800, 0xF14 = HART_ID, trap_jump_o=0.
//  2) Write 0x340 = 32'hDEAD_BEEF while reading 0x340 in the same cycle -> rdata=DEADBEEF (bypass); next cycle still DEADBEEF.
//  3) mtvec=0x100, mie=0x80, mstatus=0x8; timer_irq_i=1 with inst_addr_i=0x2C valid:
//     -> next cycle trap_jump_o=1, trap_addr_o=0x100; mepc=0x2C; mcause=0x8000_0007; mstatus=0x1880.
//  4) Then mret_i with inst_valid_i -> next cycle trap_addr_o=0x2C, mstatus.MIE=1, MPIE=1.
//  5) mtvec=0x101, ext+timer both pending and enabled -> mcause=0x8000_000B, trap_addr_o=0x12C.
//     ecall in the same cycle instead -> mcause=11, target 0x100.
//  6) Write mcycleh=32'hFFFF_FFFF, mcycle=32'hFFFF_FFFF -> next-cycle read 0xB00=0, 0xB80=0 (wrap).

Source files
------------

// File: rtl/csr_file_pkg.sv
// Shared constants for the machine-mode CSR file: CSR addresses, trap cause
// codes, sequencer states and a few small helpers.
package csr_file_pkg;

  localparam int CSR_ADDR_WIDTH = 12;

  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MSTATUS  = 12'h300;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MISA     = 12'h301;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MIE      = 12'h304;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MTVEC    = 12'h305;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MSCRATCH = 12'h340;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MEPC     = 12'h341;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MCAUSE   = 12'h342;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MIP      = 12'h344;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MHARTID  = 12'hF14;

  localparam logic [31:0] CAUSE_BREAKPOINT  = 32'd3;
  localparam logic [31:0] CAUSE_ECALL_M     = 32'd11;
  localparam logic [31:0] CAUSE_M_EXT_IRQ   = 32'h8000_000B;
  localparam logic [31:0] CAUSE_M_TIMER_IRQ = 32'h8000_0007;

  // Only MEIE (bit 11) and MTIE (bit 7) exist in mie.
  localparam logic [31:0] MIE_WMASK = 32'h0000_0880;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TRAP = 2'd1,
    S_RET  = 2'd2
  } csr_state_e;

  // mstatus as seen by software: MPP hardwired to machine mode.
  function automatic logic [31:0] mstatus_pack(input logic mpie, input logic mie);
    return {19'd0, 2'b11, 3'd0, mpie, 3'd0, mie, 3'd0};
  endfunction

  // Vectored mode only offsets interrupts; exceptions always use the base.
  function automatic logic [31:0] trap_target(input logic [31:0] mtvec, input logic [31:0] cause);
    logic [31:0] base;
    base = {mtvec[31:2], 2'b00};
    if (mtvec[0] && cause[31]) return base + {25'd0, cause[4:0], 2'b00};
    return base;
  endfunction

endpackage

// File: rtl/csr_file_if.sv
// CSR request/response bundle between the pipeline (master) and the CSR file
// (slave). There is no valid/ready pair: reads are combinational and always
// answered, a write is a single-cycle strobe qualified by csr_we_i, and trap
// requests are qualified by inst_valid_i; the CSR file never back-pressures.
interface csr_file_if;
  import csr_file_pkg::*;

  logic [CSR_ADDR_WIDTH-1:0] csr_raddr_i;
  logic [31:0]               csr_rdata_o;
  logic                      csr_we_i;
  logic [CSR_ADDR_WIDTH-1:0] csr_waddr_i;
  logic [31:0]               csr_wdata_i;
  logic                      inst_valid_i;
  logic [31:0]               inst_addr_i;
  logic                      ecall_i;
  logic                      ebreak_i;
  logic                      mret_i;
  logic                      timer_irq_i;
  logic                      ext_irq_i;
  logic                      trap_jump_o;
  logic [31:0]               trap_addr_o;

  modport master (
    output csr_raddr_i, csr_we_i, csr_waddr_i, csr_wdata_i, inst_valid_i,
           inst_addr_i, ecall_i, ebreak_i, mret_i, timer_irq_i, ext_irq_i,
    input  csr_rdata_o, trap_jump_o, trap_addr_o
  );

  modport slave (
    input  csr_raddr_i, csr_we_i, csr_waddr_i, csr_wdata_i, inst_valid_i,
           inst_addr_i, ecall_i, ebreak_i, mret_i, timer_irq_i, ext_irq_i,
    output csr_rdata_o, trap_jump_o, trap_addr_o
  );

endinterface

// File: rtl/csr_file_counter64.sv
// Free-running 64-bit cycle counter whose halves can be loaded independently.
// A load replaces one half and suppresses that cycle's increment.
module csr_file_counter64 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_lo,
  input  logic        load_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  // Count every cycle unless software is loading one half.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      count <= 64'd0;
    end else if (load_lo) begin
      count[31:0] <= wdata;
    end else if (load_hi) begin
      count[63:32] <= wdata;
    end else begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR register file and trap sequencer. Serves exe-stage reads,
// commits exe_mem writes, accepts traps/mret and issues a one-cycle redirect.
module csr_file
  import csr_file_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_1100
) (
  input  logic       clk_i,
  input  logic       rst_i,
  csr_file_if.slave  bus,
  output csr_state_e dbg_state
);

  logic        mstatus_mie, mstatus_mpie;
  logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [63:0] mcycle;
  csr_state_e  state;
  logic        trap_jump_q;
  logic [31:0] trap_addr_q;

  logic wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause;
  logic wr_mcycle, wr_mcycleh;

  assign wr_mstatus  = bus.csr_we_i && (bus.csr_waddr_i == CSR_MSTATUS);
  assign wr_mie      = bus.csr_we_i && (bus.csr_waddr_i == CSR_MIE);
  assign wr_mtvec    = bus.csr_we_i && (bus.csr_waddr_i == CSR_MTVEC);
  assign wr_mscratch = bus.csr_we_i && (bus.csr_waddr_i == CSR_MSCRATCH);
  assign wr_mepc     = bus.csr_we_i && (bus.csr_waddr_i == CSR_MEPC);
  assign wr_mcause   = bus.csr_we_i && (bus.csr_waddr_i == CSR_MCAUSE);
  assign wr_mcycle   = bus.csr_we_i && (bus.csr_waddr_i == CSR_MCYCLE);
  assign wr_mcycleh  = bus.csr_we_i && (bus.csr_waddr_i == CSR_MCYCLEH);

  // Post-write legalised views: what each CSR holds once this cycle's write
  // lands. Reading through them gives the write-first bypass for free.
  logic [31:0] mstatus_view, mie_view, mtvec_view, mscratch_view;
  logic [31:0] mepc_view, mcause_view, mcycle_lo_view, mcycle_hi_view, mip_view;

  assign mstatus_view   = wr_mstatus ? mstatus_pack(bus.csr_wdata_i[7], bus.csr_wdata_i[3])
                                     : mstatus_pack(mstatus_mpie, mstatus_mie);
  assign mie_view       = wr_mie ? (bus.csr_wdata_i & MIE_WMASK) : mie_q;
  assign mtvec_view     = (wr_mtvec ? bus.csr_wdata_i : mtvec_q) & 32'hFFFF_FFFD;
  assign mscratch_view  = wr_mscratch ? bus.csr_wdata_i : mscratch_q;
  assign mepc_view      = (wr_mepc ? bus.csr_wdata_i : mepc_q) & 32'hFFFF_FFFC;
  assign mcause_view    = wr_mcause ? bus.csr_wdata_i : mcause_q;
  assign mcycle_lo_view = wr_mcycle ? bus.csr_wdata_i : mcycle[31:0];
  assign mcycle_hi_view = wr_mcycleh ? bus.csr_wdata_i : mcycle[63:32];
  assign mip_view       = {20'd0, bus.ext_irq_i, 3'd0, bus.timer_irq_i, 7'd0};

  csr_file_counter64 u_mcycle (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_lo (wr_mcycle),
    .load_hi (wr_mcycleh),
    .wdata   (bus.csr_wdata_i),
    .count   (mcycle)
  );

  // Combinational read mux; unmapped addresses read zero.
  logic [31:0] rdata;
  always_comb begin
    rdata = 32'h0;
    case (bus.csr_raddr_i)
      CSR_MSTATUS:  rdata = mstatus_view;
      CSR_MISA:     rdata = MISA_VALUE;
      CSR_MIE:      rdata = mie_view;
      CSR_MTVEC:    rdata = mtvec_view;
      CSR_MSCRATCH: rdata = mscratch_view;
      CSR_MEPC:     rdata = mepc_view;
      CSR_MCAUSE:   rdata = mcause_view;
      CSR_MIP:      rdata = mip_view;
      CSR_MCYCLE:   rdata = mcycle_lo_view;
      CSR_MCYCLEH:  rdata = mcycle_hi_view;
      CSR_MHARTID:  rdata = HART_ID;
      default:      rdata = 32'h0;
    endcase
  end
  assign bus.csr_rdata_o = rdata;

  // Trap/mret acceptance, only in IDLE on a real instruction, fixed priority.
  logic        take_trap, take_mret, irq_ext, irq_tmr;
  logic [31:0] trap_cause;
  always_comb begin
    irq_ext    = mstatus_mie && mie_q[11] && bus.ext_irq_i;
    irq_tmr    = mstatus_mie && mie_q[7] && bus.timer_irq_i;
    take_trap  = 1'b0;
    take_mret  = 1'b0;
    trap_cause = 32'h0;
    if (state == S_IDLE && bus.inst_valid_i) begin
      if (bus.ebreak_i) begin
        take_trap  = 1'b1;
        trap_cause = CAUSE_BREAKPOINT;
      end else if (bus.ecall_i) begin
        take_trap  = 1'b1;
        trap_cause = CAUSE_ECALL_M;
      end else if (irq_ext) begin
        take_trap  = 1'b1;
        trap_cause = CAUSE_M_EXT_IRQ;
      end else if (irq_tmr) begin
        take_trap  = 1'b1;
        trap_cause = CAUSE_M_TIMER_IRQ;
      end else if (bus.mret_i) begin
        take_mret  = 1'b1;
      end
    end
  end

  // CSR storage: software writes, with trap/mret overriding mstatus/mepc/mcause.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_q        <= 32'h0;
      mtvec_q      <= MTVEC_RESET;
      mscratch_q   <= 32'h0;
      mepc_q       <= 32'h0;
      mcause_q     <= 32'h0;
    end else begin
      if (wr_mie)      mie_q      <= mie_view;
      if (wr_mtvec)    mtvec_q    <= mtvec_view;
      if (wr_mscratch) mscratch_q <= mscratch_view;
      if (take_trap) begin
        mepc_q       <= bus.inst_addr_i;
        mcause_q     <= trap_cause;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else begin
        if (wr_mepc)   mepc_q   <= mepc_view;
        if (wr_mcause) mcause_q <= mcause_view;
        if (take_mret) begin
          mstatus_mie  <= mstatus_mpie;
          mstatus_mpie <= 1'b1;
        end else if (wr_mstatus) begin
          mstatus_mie  <= bus.csr_wdata_i[3];
          mstatus_mpie <= bus.csr_wdata_i[7];
        end
      end
    end
  end

  // Sequencer: one redirect cycle after each accepted trap or mret.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= S_IDLE;
      trap_jump_q <= 1'b0;
      trap_addr_q <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (take_trap) begin
            state       <= S_TRAP;
            trap_jump_q <= 1'b1;
            trap_addr_q <= trap_target(mtvec_view, trap_cause);
          end else if (take_mret) begin
            state       <= S_RET;
            trap_jump_q <= 1'b1;
            trap_addr_q <= mepc_view;
          end else begin
            trap_jump_q <= 1'b0;
            trap_addr_q <= 32'h0;
          end
        end
        default: begin
          state       <= S_IDLE;
          trap_jump_q <= 1'b0;
          trap_addr_q <= 32'h0;
        end
      endcase
    end
  end

  assign bus.trap_jump_o = trap_jump_q;
  assign bus.trap_addr_o = trap_addr_q;
  assign dbg_state       = state;

endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: directed stimulus, a cycle-level CSR model checked on
// every negative edge, and literal spot checks of the worked examples.
module tb_csr_file;
  import csr_file_pkg::*;

  localparam logic [31:0] MTVEC_RST = 32'h0000_0040;
  localparam logic [31:0] HART      = 32'd5;
  localparam logic [31:0] MISA      = 32'h4000_1100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  csr_state_e dbg_state;

  csr_file_if bus();

  csr_file #(
    .MTVEC_RESET (MTVEC_RST),
    .HART_ID     (HART),
    .MISA_VALUE  (MISA)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        mie_b;
    logic        mpie_b;
    logic [31:0] mie;
    logic [31:0] mtvec;
    logic [31:0] mscratch;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [63:0] cyc;
  } csr_model_t;

  function automatic csr_model_t reset_state();
    csr_model_t s;
    s.mie_b = 1'b0; s.mpie_b = 1'b0; s.mie = 32'h0; s.mtvec = MTVEC_RST;
    s.mscratch = 32'h0; s.mepc = 32'h0; s.mcause = 32'h0; s.cyc = 64'd0;
    return s;
  endfunction

  function automatic csr_model_t apply_write(input csr_model_t s, input logic we,
                                             input logic [11:0] a, input logic [31:0] d);
    csr_model_t r;
    r = s;
    if (we) begin
      case (a)
        12'h300: begin r.mie_b = d[3]; r.mpie_b = d[7]; end
        12'h304: r.mie = d & 32'h0000_0880;
        12'h305: r.mtvec = d;
        12'h340: r.mscratch = d;
        12'h341: r.mepc = d;
        12'h342: r.mcause = d;
        12'hB00: r.cyc[31:0] = d;
        12'hB80: r.cyc[63:32] = d;
        default: ;
      endcase
    end
    return r;
  endfunction

  function automatic logic [31:0] lookup(input csr_model_t s, input logic [11:0] a,
                                         input logic tmr, input logic ext);
    case (a)
      12'h300: return 32'h1800 | (s.mpie_b ? 32'h80 : 32'h0) | (s.mie_b ? 32'h8 : 32'h0);
      12'h301: return MISA;
      12'h304: return s.mie;
      12'h305: return s.mtvec & 32'hFFFF_FFFD;
      12'h340: return s.mscratch;
      12'h341: return s.mepc & 32'hFFFF_FFFC;
      12'h342: return s.mcause;
      12'h344: return (tmr ? 32'h80 : 32'h0) | (ext ? 32'h800 : 32'h0);
      12'hB00: return s.cyc[31:0];
      12'hB80: return s.cyc[63:32];
      12'hF14: return HART;
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- scoreboard / compare process ----------------
  logic [31:0] exp_q[$];
  csr_model_t  cur;
  logic        redirect_now = 1'b0;

  initial begin : compare
    csr_model_t  pw, nx;
    logic        want_jump, take, redirect_next, cyc_wr;
    logic [31:0] want_addr, cause, tgt;
    cur = reset_state();
    @(posedge clk);
    forever begin
      @(negedge clk);
      pw = apply_write(cur, bus.csr_we_i, bus.csr_waddr_i, bus.csr_wdata_i);
      check("rdata", bus.csr_rdata_o,
            lookup(pw, bus.csr_raddr_i, bus.timer_irq_i, bus.ext_irq_i));
      if (redirect_now && exp_q.size() > 0) begin
        want_jump = 1'b1;
        want_addr = exp_q.pop_front();
      end else begin
        want_jump = 1'b0;
        want_addr = 32'h0;
      end
      check("trap_jump", {31'd0, bus.trap_jump_o}, {31'd0, want_jump});
      check("trap_addr", bus.trap_addr_o, want_addr);

      redirect_next = 1'b0;
      if (!rst) begin
        nx = reset_state();
        exp_q.delete();
      end else begin
        nx = pw;
        cyc_wr = bus.csr_we_i && (bus.csr_waddr_i == 12'hB00 || bus.csr_waddr_i == 12'hB80);
        if (!cyc_wr) nx.cyc = cur.cyc + 64'd1;
        if (!redirect_now && bus.inst_valid_i) begin
          take  = 1'b1;
          cause = 32'h0;
          if (bus.ebreak_i) cause = 32'd3;
          else if (bus.ecall_i) cause = 32'd11;
          else if (bus.ext_irq_i && cur.mie[11] && cur.mie_b) cause = 32'h8000_000B;
          else if (bus.timer_irq_i && cur.mie[7] && cur.mie_b) cause = 32'h8000_0007;
          else take = 1'b0;
          if (take) begin
            nx.mepc   = bus.inst_addr_i;
            nx.mcause = cause;
            nx.mpie_b = cur.mie_b;
            nx.mie_b  = 1'b0;
            tgt = pw.mtvec & 32'hFFFF_FFFC;
            if (cause[31] && pw.mtvec[0]) tgt = tgt + (cause & 32'h1F) * 4;
            exp_q.push_back(tgt);
            redirect_next = 1'b1;
          end else if (bus.mret_i) begin
            nx.mie_b  = cur.mpie_b;
            nx.mpie_b = 1'b1;
            exp_q.push_back(pw.mepc & 32'hFFFF_FFFC);
            redirect_next = 1'b1;
          end
        end
      end
      cur = nx;
      redirect_now = redirect_next;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.csr_raddr_i = 12'h0; bus.csr_we_i = 1'b0; bus.csr_waddr_i = 12'h0;
    bus.csr_wdata_i = 32'h0; bus.inst_valid_i = 1'b0; bus.inst_addr_i = 32'h0;
    bus.ecall_i = 1'b0; bus.ebreak_i = 1'b0; bus.mret_i = 1'b0;
    bus.timer_irq_i = 1'b0; bus.ext_irq_i = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    bus.csr_we_i = 1'b1; bus.csr_waddr_i = a; bus.csr_wdata_i = d;
    step();
    bus.csr_we_i = 1'b0;
  endtask

  task automatic peek(input logic [11:0] a, input string name, input logic [31:0] exp);
    bus.csr_raddr_i = a;
    #1;
    check(name, bus.csr_rdata_o, exp);
  endtask

  task automatic instr(input logic [31:0] pc, input logic ec, input logic eb, input logic mr);
    bus.inst_valid_i = 1'b1; bus.inst_addr_i = pc;
    bus.ecall_i = ec; bus.ebreak_i = eb; bus.mret_i = mr;
    step();
    bus.inst_valid_i = 1'b0; bus.ecall_i = 1'b0; bus.ebreak_i = 1'b0; bus.mret_i = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stimulus
    idle_inputs();
    rst = 1'b0;
    step(); step();
    rst = 1'b1;

    // Reset state
    peek(12'h305, "reset_mtvec", MTVEC_RST);
    peek(12'h300, "reset_mstatus", 32'h0000_1800);
    peek(12'hF14, "reset_mhartid", HART);
    check("reset_jump", {31'd0, bus.trap_jump_o}, 32'd0);

    // Write-first bypass, then the stored value
    bus.csr_we_i = 1'b1; bus.csr_waddr_i = 12'h340; bus.csr_wdata_i = 32'hDEAD_BEEF;
    peek(12'h340, "bypass_mscratch", 32'hDEAD_BEEF);
    step();
    bus.csr_we_i = 1'b0;
    peek(12'h340, "stored_mscratch", 32'hDEAD_BEEF);

    // Legalisation and read-only / unmapped addresses
    wr(12'h301, 32'h0);
    peek(12'h301, "misa_ro", MISA);
    wr(12'h7C0, 32'h1234_5678);
    peek(12'h7C0, "unmapped", 32'h0);
    wr(12'h304, 32'hFFFF_FFFF);
    peek(12'h304, "mie_mask", 32'h0000_0880);
    wr(12'h305, 32'hFFFF_FFFF);
    peek(12'h305, "mtvec_bit1", 32'hFFFF_FFFD);
    wr(12'h341, 32'h0000_0123);
    peek(12'h341, "mepc_align", 32'h0000_0120);

    // Timer interrupt, direct mode
    wr(12'h305, 32'h0000_0100);
    wr(12'h304, 32'h0000_0080);
    wr(12'h300, 32'h0000_0008);
    bus.timer_irq_i = 1'b1;
    instr(32'h0000_002C, 1'b0, 1'b0, 1'b0);
    bus.timer_irq_i = 1'b0;
    check("mti_jump", {31'd0, bus.trap_jump_o}, 32'd1);
    check("mti_state", {31'd0, dbg_state == S_TRAP}, 32'd1);
    peek(12'h341, "mti_mepc", 32'h0000_002C);
    peek(12'h342, "mti_mcause", 32'h8000_0007);
    check("mti_addr", bus.trap_addr_o, 32'h0000_0100);
    step();
    peek(12'h300, "mti_mstatus", 32'h0000_1880);

    // mret back to the trapped PC
    instr(32'h0000_0100, 1'b0, 1'b0, 1'b1);
    check("mret_addr", bus.trap_addr_o, 32'h0000_002C);
    peek(12'h300, "mret_mstatus", 32'h0000_1888);
    step();

    // Vectored mode: external beats timer
    wr(12'h305, 32'h0000_0101);
    wr(12'h304, 32'h0000_0880);
    bus.timer_irq_i = 1'b1; bus.ext_irq_i = 1'b1;
    instr(32'h0000_0040, 1'b0, 1'b0, 1'b0);
    bus.timer_irq_i = 1'b0; bus.ext_irq_i = 1'b0;
    check("mei_addr", bus.trap_addr_o, 32'h0000_012C);
    peek(12'h342, "mei_mcause", 32'h8000_000B);
    step();

    // ecall beats both pending interrupts; synchronous cause uses the base
    wr(12'h300, 32'h0000_0008);
    bus.timer_irq_i = 1'b1; bus.ext_irq_i = 1'b1;
    instr(32'h0000_0048, 1'b1, 1'b0, 1'b0);
    bus.timer_irq_i = 1'b0; bus.ext_irq_i = 1'b0;
    check("ecall_addr", bus.trap_addr_o, 32'h0000_0100);
    peek(12'h342, "ecall_mcause", 32'd11);
    peek(12'h341, "ecall_mepc", 32'h0000_0048);
    step();

    // ebreak beats ecall
    instr(32'h0000_0050, 1'b1, 1'b1, 1'b0);
    peek(12'h342, "ebreak_mcause", 32'd3);
    step();

    // MIE clear: pending enabled timer is ignored
    bus.timer_irq_i = 1'b1;
    instr(32'h0000_0060, 1'b0, 1'b0, 1'b0);
    check("mie_off_nojump", {31'd0, bus.trap_jump_o}, 32'd0);
    bus.timer_irq_i = 1'b0;

    // Interrupt withdrawn before a valid instruction arrives
    wr(12'h300, 32'h0000_0008);
    bus.ext_irq_i = 1'b1;
    step();
    bus.ext_irq_i = 1'b0;
    instr(32'h0000_0064, 1'b0, 1'b0, 1'b0);
    check("cancel_nojump", {31'd0, bus.trap_jump_o}, 32'd0);

    // mcycle wrap across both halves
    wr(12'hB80, 32'hFFFF_FFFF);
    wr(12'hB00, 32'hFFFF_FFFF);
    peek(12'hB00, "cyc_lo_loaded", 32'hFFFF_FFFF);
    step();
    peek(12'hB80, "cyc_hi_wrap", 32'h0);
    step();
    peek(12'hB00, "cyc_lo_after", 32'h1);

    // Reset wins over a trap accepted on the same edge
    rst = 1'b0;
    instr(32'h0000_0070, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    check("rst_nojump", {31'd0, bus.trap_jump_o}, 32'd0);
    peek(12'h342, "rst_mcause", 32'h0);
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
